// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue slice.
//   FqXlen   : default address / instruction width
//   FqDepth  : default number of queue entries
//   PcIncr   : sequential PC step used for dec_pc4_o
//   NopInstr : canonical NOP encoding
package fetch_queue_pkg;

    localparam int unsigned FqXlen  = 32;
    localparam int unsigned FqDepth = 4;
    localparam int unsigned PcIncr  = 4;
    localparam logic [31:0] NopInstr = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of fetch-side and decode-side signals of the fetch queue.
// Signal suffixes are from the queue's point of view.
//   fetch_valid_i, pc_i, instr_i, flush_i, dec_ready_i : driven by the pipeline (master)
//   fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o,
//   dec_pc4_o, count_o                                 : driven by the queue (slave)
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned XLEN  = FqXlen,
    parameter int unsigned DEPTH = FqDepth
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            fetch_valid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic            fetch_ready_o;
    logic            flush_i;
    logic            dec_ready_i;
    logic            dec_valid_o;
    logic [XLEN-1:0] dec_pc_o;
    logic [XLEN-1:0] dec_instr_o;
    logic [XLEN-1:0] dec_pc4_o;
    logic [CntW-1:0] count_o;

    modport master (
        output fetch_valid_i, pc_i, instr_i, flush_i, dec_ready_i,
        input  fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o, dec_pc4_o, count_o
    );

    modport slave (
        input  fetch_valid_i, pc_i, instr_i, flush_i, dec_ready_i,
        output fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o, dec_pc4_o, count_o
    );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch and decode stages.
// Circular buffer of {pc, instr} with show-ahead head output.
//   clk_i  : clock, all state on rising edge
//   rst_i  : synchronous active-high reset
//   fq_io  : fetch_queue_if.slave
//            push side  : fetch_valid_i, pc_i, instr_i, fetch_ready_o
//            pop side   : dec_ready_i, dec_valid_o, dec_pc_o, dec_instr_o, dec_pc4_o
//            control    : flush_i (discard all entries), count_o (occupancy)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FqDepth,
    parameter int unsigned XLEN  = FqXlen
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_queue_if.slave fq_io
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic full, empty, push, pop;

    // Ready/valid come from the registered count only, so fetch_ready_o never
    // depends on dec_ready_i; a pop while full frees the slot one cycle later.
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = fq_io.fetch_valid_i && !full && !fq_io.flush_i;
    assign pop   = fq_io.dec_ready_i && !empty && !fq_io.flush_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (fq_io.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; outputs are masked while empty instead.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            pc_mem_q[tail_q]    <= fq_io.pc_i;
            instr_mem_q[tail_q] <= fq_io.instr_i;
        end
    end

    assign fq_io.fetch_ready_o = !full;
    assign fq_io.dec_valid_o   = !empty;
    assign fq_io.count_o       = count_q;
    assign fq_io.dec_pc_o      = empty ? '0 : pc_mem_q[head_q];
    assign fq_io.dec_instr_o   = empty ? XLEN'(NopInstr) : instr_mem_q[head_q];
    assign fq_io.dec_pc4_o     = fq_io.dec_pc_o + XLEN'(PcIncr);

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have a parameter XLEN, default 32, giving the address and instruction width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 fetch_valid_i  input  1  pc_i/instr_i hold a fetched instruction this cycle.
REQ-006 pc_i  input  XLEN  address of the fetched instruction (PC register output).
REQ-007 instr_i  input  XLEN  instruction-memory read data for pc_i.
REQ-008 fetch_ready_o  output  1  queue can accept; when low, the PC register SHALL hold (stall).
REQ-009 flush_i  input  1  taken branch/jump; discard all queued entries.
REQ-010 dec_ready_i  input  1  decode stage consumes the head entry this cycle.
REQ-011 dec_valid_o  output  1  head entry is valid.
REQ-012 dec_pc_o  output  XLEN  PC of the head entry.
REQ-013 dec_instr_o  output  XLEN  instruction of the head entry.
REQ-014 dec_pc4_o  output  XLEN  dec_pc_o + 4, modulo 2^XLEN.
REQ-015 count_o  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Push SHALL occur when fetch_valid_i && fetch_ready_o && !flush_i; it writes {pc_i, instr_i} at the tail.
REQ-017 Pop SHALL occur when dec_valid_o && dec_ready_i && !flush_i; it advances the head.
REQ-018 fetch_ready_o SHALL equal (count_o != DEPTH), derived from registered state only, with no combinational path from dec_ready_i.
REQ-019 dec_valid_o SHALL equal (count_o != 0); dec_* outputs SHALL present the head entry show-ahead in the same cycle it becomes valid, with no extra latency.
REQ-020 When empty, dec_pc_o and dec_instr_o SHALL be 0 and dec_pc4_o SHALL be 4.
REQ-021 Push-to-visible latency SHALL be one cycle: an entry pushed into an empty queue at edge N is on dec_* during cycle N+1.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; this is legal at any non-empty, non-full occupancy.
REQ-023 When full, fetch_ready_o is low, so a same-cycle pop SHALL NOT enable a push; the freed slot is offered on the next cycle.
REQ-024 Head and tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 flush_i SHALL have priority over push and pop: on the next edge count becomes 0, both pointers return to 0, and the fetch_valid_i data of the flush cycle is dropped.
REQ-026 fetch_valid_i while fetch_ready_o is low SHALL be ignored, with no state change.
REQ-027 Pop while empty cannot occur, since dec_valid_o is low; dec_ready_i is then ignored.

Reset
REQ-028 While rst_i is high at a clock edge, the block SHALL set count=0 and pointers=0, giving dec_valid_o=0, fetch_ready_o=1 and dec_pc_o=dec_instr_o=0.
REQ-029 Reset SHALL override flush, push and pop in the same cycle; a reset mid-operation discards all entries.
REQ-030 Storage array contents need not be reset, but dec_* outputs SHALL be masked to 0 while empty.

Structure
REQ-031 A shared package SHALL hold XLEN, the default DEPTH, the PC increment constant 4 and the NOP encoding 32'h00000000.
REQ-032 No sub-module SHALL be used; storage, pointers and count SHALL all reside in fetch_queue.

Verification
REQ-033 Reset: assert rst_i for 2 cycles with fetch_valid_i=1 -> count_o=0, dec_valid_o=0, fetch_ready_o=1, dec_pc4_o=4.
REQ-034 Fill: push PCs 0x00, 0x04, 0x08, 0x0C with dec_ready_i=0 -> count_o=4, fetch_ready_o=0, dec_pc_o=0x00; a fifth push of 0x10 is ignored.
REQ-035 Drain with wrap: from full, pop 2 and push 0x10, 0x14 -> order out is 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14, and dec_pc4_o=0x18 when 0x14 is at the head.
REQ-036 Full plus pop: full, dec_ready_i=1, fetch_valid_i=1 -> that cycle's fetch is not accepted, count_o=3 the next cycle, and fetch_ready_o=1.
REQ-037 Flush: count_o=3, flush_i=1 together with fetch_valid_i=1 (pc 0x40) and dec_ready_i=1 -> the next cycle has count_o=0 and dec_valid_o=0; the following push of 0x80 appears as dec_pc_o=0x80 one cycle later.
REQ-038 Wrap at top: dec_pc_o=0xFFFFFFFC -> dec_pc4_o=0x00000000.
